// File: rtl/pipes_pkg.sv
// pipes_pkg: constants and types shared by the difference-square stream.
//   VARWIDTH       : lane operand/result width (only 32 is supported)
//   DIFFSQ_LATENCY : register stages between an input transfer and out_valid
//   FLOAT_ZERO     : IEEE-754 single-precision +0.0, driven on idle/masked lanes
//   stage_t        : one pipeline stage of a lane (valid, mask, overflow, data)
package pipes_pkg;

  localparam int VARWIDTH       = 32;
  localparam int DIFFSQ_LATENCY = 3;
  localparam logic [31:0] FLOAT_ZERO = 32'h0000_0000;

  typedef struct packed {
    logic                v;
    logic                m;
    logic                ovf;
    logic [VARWIDTH-1:0] data;
  } stage_t;

endpackage

// File: rtl/adder32.sv
// adder32: plain 32-bit wrapping adder with carry-in.
//   a, b : addends
//   cin  : carry in
//   sum  : a + b + cin, modulo 2^32
module adder32 (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        cin,
  output logic [31:0] sum
);

  assign sum = a + b + {31'b0, cin};

endmodule

// File: rtl/diffsquared32_pipe.sv
// diffsquared32_pipe: one lane of the stream, three register stages.
//   S1: wrapped difference a-b plus signed-overflow flag
//   S2: difference converted to single precision
//   S3: the float squared
// All stages shift together when advance=1 and hold otherwise; RST wins.
//   CLK, RST   : clock, synchronous active-high reset
//   advance    : pipeline shift enable from the top-level handshake
//   a, b, mask : lane operands and lane enable, captured into S1
//   in_v       : valid bit captured into S1
//   out, ovf   : lane result and overflow flag (zero unless valid and enabled)
//   out_v      : S3 valid bit
module diffsquared32_pipe
  import pipes_pkg::*;
(
  input  logic                CLK,
  input  logic                RST,
  input  logic                advance,
  input  logic [VARWIDTH-1:0] a,
  input  logic [VARWIDTH-1:0] b,
  input  logic                mask,
  input  logic                in_v,
  output logic [VARWIDTH-1:0] out,
  output logic                ovf,
  output logic                out_v
);

  stage_t s1_q, s1_d;
  stage_t s2_q, s2_d;
  stage_t s3_q, s3_d;

  logic [VARWIDTH-1:0] diff_w;
  logic [VARWIDTH-1:0] float_w;
  logic [VARWIDTH-1:0] sq_w;
  logic                ovf_w;

  // a - b as a + ~b + 1 so the subtractor is the shared adder.
  adder32 u_sub (
    .a   (a),
    .b   (~b),
    .cin (1'b1),
    .sum (diff_w)
  );

  // Overflow only when operand signs differ and the result sign leaves a's.
  assign ovf_w = (a[31] != b[31]) & (diff_w[31] != a[31]);

  int2float32 u_cvt (
    .a (s1_q.data),
    .f (float_w)
  );

  square_f32 u_sq (
    .x (s2_q.data),
    .y (sq_w)
  );

  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (advance) begin
      s1_d = '{v: in_v,   m: mask,   ovf: ovf_w,   data: diff_w};
      s2_d = '{v: s1_q.v, m: s1_q.m, ovf: s1_q.ovf, data: float_w};
      s3_d = '{v: s2_q.v, m: s2_q.m, ovf: s2_q.ovf, data: sq_w};
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out   = (s3_q.v & s3_q.m) ? s3_q.data : FLOAT_ZERO;
  assign ovf   = s3_q.v & s3_q.m & s3_q.ovf;
  assign out_v = s3_q.v;

endmodule

// File: rtl/int2float32.sv
// int2float32: signed 32-bit integer to IEEE-754 single precision,
// round-to-nearest-even.
//   a : two's-complement integer
//   f : single-precision value of a (0 -> +0.0)
module int2float32 (
  input  logic [31:0] a,
  output logic [31:0] f
);

  logic        sign;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  lead;
  logic [7:0]  expo;
  logic        rnd;

  always_comb begin
    sign = a[31];
    // -2^31 negates to 32'h8000_0000, which is the correct unsigned magnitude.
    mag  = sign ? (~a + 32'd1) : a;
    lead = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) lead = 5'(i);
    end
    norm = mag << (5'd31 - lead);
    expo = 8'd127 + {3'b0, lead};
    // 23 fraction bits are norm[30:8]; guard is norm[7], sticky is the rest.
    rnd  = norm[7] & ((|norm[6:0]) | norm[8]);
    // Carry out of the fraction bumps the exponent, which is the right result.
    f    = {sign, expo, norm[30:8]} + {31'b0, rnd};
    // No leading one after normalisation means the input was zero.
    if (!norm[31]) f = 32'h0;
  end

endmodule

// File: rtl/square_f32.sv
// square_f32: IEEE-754 single-precision x*x, round-to-nearest-even.
//   x : operand
//   y : x squared; zero/subnormal inputs and underflow flush to +0,
//       overflow saturates to +inf, NaN is returned quieted.
module square_f32 (
  input  logic [31:0] x,
  output logic [31:0] y
);

  logic [7:0]  e;
  logic [22:0] frac;
  logic [47:0] prod;
  logic [9:0]  e_res;
  logic [22:0] mant;
  logic        guard;
  logic        sticky;

  always_comb begin
    e     = x[30:23];
    frac  = x[22:0];
    prod  = 48'({1'b1, frac}) * 48'({1'b1, frac});
    // Product of two [1,2) significands lies in [1,4); prod[47] marks [2,4).
    e_res = {1'b0, e, 1'b0} - 10'd127 + {9'b0, prod[47]};
    if (prod[47]) begin
      mant   = prod[46:24];
      guard  = prod[23];
      sticky = |prod[22:0];
    end else begin
      mant   = prod[45:23];
      guard  = prod[22];
      sticky = |prod[21:0];
    end
    y = {1'b0, e_res[7:0], mant} + {31'b0, guard & (sticky | mant[0])};
    if (e == 8'd0) begin
      y = 32'h0;
    end else if (e == 8'hFF) begin
      y = (frac != '0) ? (x | 32'h0040_0000) : 32'h7F80_0000;
    end else if (e_res[9] || (e_res == 10'd0)) begin
      y = 32'h0;
    end else if (e_res >= 10'd255) begin
      y = 32'h7F80_0000;
    end
  end

endmodule

// File: rtl/pipes_diffsquare_stream.sv
// pipes_diffsquare_stream: LANES parallel (vals0-vals1)^2 lanes with a
// valid/ready stream interface and a global hold.
//   CLK, RST            : clock, synchronous active-high reset
//   EN                  : global hold; 0 freezes the pipeline
//   in_valid, in_ready  : input handshake (in_ready is combinational)
//   vals0, vals1        : packed signed operands, lane k at [k*32 +: 32]
//   lane_mask           : per-lane enable, sampled with the data
//   out_valid, out_ready: output handshake
//   pipeout             : packed single-precision results
//   ovf                 : per-lane subtraction overflow flags
module pipes_diffsquare_stream #(
  parameter int LANES    = 16,
  parameter int VARWIDTH = pipes_pkg::VARWIDTH
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      EN,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [VARWIDTH*LANES-1:0] vals0,
  input  logic [VARWIDTH*LANES-1:0] vals1,
  input  logic [LANES-1:0]          lane_mask,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [VARWIDTH*LANES-1:0] pipeout,
  output logic [LANES-1:0]          ovf
);

  import pipes_pkg::*;

  if (VARWIDTH != 32) begin : g_bad_width
    $error("pipes_diffsquare_stream: VARWIDTH must be 32");
  end
  if ((LANES < 1) || (LANES > 64)) begin : g_bad_lanes
    $error("pipes_diffsquare_stream: LANES must be in 1..64");
  end

  logic             advance;
  logic [LANES-1:0] out_v_all;

  // Shift whenever the output slot is empty or being drained.
  assign advance  = EN & (~out_valid | out_ready);
  assign in_ready = advance & ~RST;

  for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
    diffsquared32_pipe u_lane (
      .CLK     (CLK),
      .RST     (RST),
      .advance (advance),
      .a       (vals0[gi*VARWIDTH +: VARWIDTH]),
      .b       (vals1[gi*VARWIDTH +: VARWIDTH]),
      .mask    (lane_mask[gi]),
      .in_v    (in_valid),
      .out     (pipeout[gi*VARWIDTH +: VARWIDTH]),
      .ovf     (ovf[gi]),
      .out_v   (out_v_all[gi])
    );
  end

  // Lanes share every control input, so their valid bits are identical.
  assign out_valid = &out_v_all;

endmodule

// File: tb/tb_pipes_diffsquare_stream.sv
module tb_pipes_diffsquare_stream;

  localparam int L = 16;
  localparam int W = L * 32;

  logic         CLK;
  logic         rst;
  logic         en;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] vals0;
  logic [W-1:0] vals1;
  logic [L-1:0] lane_mask;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] pipeout;
  logic [L-1:0] ovf;

  pipes_diffsquare_stream #(.LANES(L), .VARWIDTH(32)) dut (
    .CLK       (CLK),
    .RST       (rst),
    .EN        (en),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .vals0     (vals0),
    .vals1     (vals1),
    .lane_mask (lane_mask),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .pipeout   (pipeout),
    .ovf       (ovf)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  // Transfer-level reference: each accepted vector carries the number of
  // pipeline advances it has seen; it is presented once it has seen three.
  typedef struct {
    logic [W-1:0] res;
    logic [L-1:0] ovf;
    int           age;
    int           id;
    int           kind;
  } ent_t;

  ent_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   n_pop    = 0;
  int   n_dut_out = 0;
  int   n_in     = 0;
  int   cur_kind = 0;
  bit   last_acc = 1'b0;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Round a real (double) to the nearest single-precision value, ties to even.
  function automatic logic [31:0] to_single(input real r);
    logic [63:0] d;
    logic [31:0] s;
    d = $realtobits(r);
    if (d[62:0] == '0) return 32'h0;
    s = {d[63], 8'(d[62:52] - 11'd896), d[51:29]};
    if (d[28] && ((d[27:0] != '0) || d[29])) s = s + 32'd1;
    return s;
  endfunction

  function automatic real s2r(input logic [31:0] s);
    logic [63:0] d;
    if (s[30:0] == '0) return 0.0;
    d = {s[31], 11'({3'b0, s[30:23]} + 11'd896), s[22:0], 29'b0};
    return $bitstoreal(d);
  endfunction

  task automatic ref_vec(input logic [W-1:0] a, input logic [W-1:0] b, input logic [L-1:0] m,
                         output logic [W-1:0] res, output logic [L-1:0] o);
    longint      d;
    int          di;
    logic [31:0] f;
    logic [31:0] ak;
    logic [31:0] bk;
    res = '0;
    o   = '0;
    for (int k = 0; k < L; k++) begin
      ak = a[k*32 +: 32];
      bk = b[k*32 +: 32];
      if (m[k]) begin
        d    = longint'(signed'(ak)) - longint'(signed'(bk));
        o[k] = (d > 64'sd2147483647) || (d < -64'sd2147483648);
        di   = int'(d[31:0]);
        f    = to_single(real'(di));
        res[k*32 +: 32] = to_single(s2r(f) * s2r(f));
      end
    end
  endtask

  task automatic cycle();
    bit   ev;
    bit   er;
    ent_t e;
    #1;
    ev = (q.size() > 0) && (q[0].age == 3);
    chk("out_valid", W'(out_valid), W'(ev));
    chk("pipeout", pipeout, ev ? q[0].res : '0);
    chk("ovf", W'(ovf), ev ? W'(q[0].ovf) : '0);
    er = !rst && en && (!ev || out_ready);
    chk("in_ready", W'(in_ready), W'(er));
    if (ev) begin
      case (q[0].kind)
        1: begin
          chk("t1 lane0", W'(pipeout[31:0]), W'(32'h4110_0000));
          chk("t1 ovf", W'(ovf), '0);
        end
        2: begin
          chk("t2 lane0", W'(pipeout[31:0]), W'(32'h4110_0000));
          chk("t2 ovf", W'(ovf), W'(16'h0002));
        end
        3: begin
          for (int k = 0; k < L; k++)
            chk($sformatf("t3 lane%0d", k), W'(pipeout[k*32 +: 32]),
                (k < 8) ? W'(32'h4180_0000) : '0);
        end
        default: ;
      endcase
    end
    if (!rst && out_valid && out_ready && en) n_dut_out++;
    last_acc = in_valid && er;
    @(posedge CLK);
    if (rst) begin
      q.delete();
    end else if (er) begin
      if (ev) begin
        $display("OUT id=%0d lane0=%08h ovf=%04h", q[0].id, q[0].res[31:0], q[0].ovf);
        void'(q.pop_front());
        n_pop++;
      end
      foreach (q[i]) begin
        e = q[i];
        e.age++;
        q[i] = e;
      end
      if (in_valid) begin
        ref_vec(vals0, vals1, lane_mask, e.res, e.ovf);
        e.age  = 1;
        e.id   = n_in;
        e.kind = cur_kind;
        n_in++;
        q.push_back(e);
      end
    end
    #1;
  endtask

  function automatic logic [W-1:0] rnd_vec();
    logic [W-1:0] v;
    for (int k = 0; k < L; k++) begin
      case ($urandom_range(0, 5))
        0:       v[k*32 +: 32] = 32'h7FFF_FFFF;
        1:       v[k*32 +: 32] = 32'h8000_0000;
        2:       v[k*32 +: 32] = 32'($urandom_range(0, 15));
        default: v[k*32 +: 32] = $urandom;
      endcase
    end
    return v;
  endfunction

  // Producer: keep an unaccepted vector on the bus, otherwise offer a new one.
  task automatic next_input(input bit want);
    if (in_valid && !last_acc) return;
    cur_kind = 0;
    if (want) begin
      in_valid  = 1'b1;
      vals0     = rnd_vec();
      vals1     = rnd_vec();
      lane_mask = $urandom_range(0, 1) ? 16'hFFFF : 16'($urandom);
    end else begin
      in_valid = 1'b0;
    end
  endtask

  initial begin
    logic [W-1:0] va;
    logic [W-1:0] vb;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    vals0 = '0; vals1 = '0; lane_mask = '0;
    repeat (2) @(posedge CLK);
    #1;
    cycle();                         // outputs idle and in_ready low during reset
    rst = 1'b0;
    cycle();

    // 5 - 2 on lane 0 only
    va = '0; vb = '0;
    va[31:0] = 32'd5; vb[31:0] = 32'd2;
    vals0 = va; vals1 = vb; lane_mask = 16'h0001; in_valid = 1'b1; cur_kind = 1;
    cycle();
    in_valid = 1'b0; cur_kind = 0;
    repeat (5) cycle();

    // 2 - 5 on lane 0, overflow on lane 1
    va = '0; vb = '0;
    va[31:0] = 32'd2;          vb[31:0] = 32'd5;
    va[63:32] = 32'h7FFF_FFFF; vb[63:32] = 32'hFFFF_FFFF;
    vals0 = va; vals1 = vb; lane_mask = 16'hFFFF; in_valid = 1'b1; cur_kind = 2;
    cycle();
    in_valid = 1'b0; cur_kind = 0;
    repeat (5) cycle();

    // half-masked vector, 7 - 3 everywhere
    for (int k = 0; k < L; k++) begin
      va[k*32 +: 32] = 32'd7;
      vb[k*32 +: 32] = 32'd3;
    end
    vals0 = va; vals1 = vb; lane_mask = 16'h00FF; in_valid = 1'b1; cur_kind = 3;
    cycle();
    in_valid = 1'b0; cur_kind = 0;
    repeat (5) cycle();

    // four back-to-back vectors, output stalled from cycle 3 for six cycles
    begin
      int sent;
      sent = 0;
      for (int c = 0; c < 18; c++) begin
        if (last_acc && in_valid) sent++;
        out_ready = (c < 3) || (c >= 9);
        next_input(sent < 4);
        cycle();
      end
      in_valid = 1'b0;
      out_ready = 1'b1;
    end

    // two vectors in flight, then a one-cycle reset
    next_input(1'b1); cycle();
    next_input(1'b1); cycle();
    in_valid = 1'b0;
    rst = 1'b1; cycle();
    rst = 1'b0;
    repeat (6) cycle();

    // EN low for five cycles mid-stream
    for (int c = 0; c < 16; c++) begin
      en = !((c >= 4) && (c < 9));
      next_input(c < 9);
      cycle();
    end
    en = 1'b1;

    // randomized traffic
    for (int c = 0; c < 800; c++) begin
      next_input($urandom_range(0, 3) != 0);
      en        = ($urandom_range(0, 9) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      rst       = ($urandom_range(0, 149) == 0);
      cycle();
    end

    // drain
    rst = 1'b0; en = 1'b1; out_ready = 1'b1;
    if (!(in_valid && !last_acc)) in_valid = 1'b0;
    for (int c = 0; c < 30; c++) begin
      cycle();
      in_valid = 1'b0;
    end
    chk("out count", W'(n_dut_out), W'(n_pop));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule
